// File: rtl/seq_detect_param.sv
// Serial sequence detector: runtime-loadable WIDTH-bit pattern, overlap mode, saturating match count.
// flag is registered on the edge that samples the last pattern bit; no backpressure, seq_vld only qualifies seq.
module seq_detect_param #(
   parameter int               WIDTH       = 5,
   parameter logic [WIDTH-1:0] DEFAULT_PAT = 5'b10010,
   parameter bit               OVERLAP     = 1'b1,
   parameter int               CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seq,
   input  logic             seq_vld,
   input  logic [WIDTH-1:0] pat_in,
   input  logic             pat_load,
   input  logic             cnt_clr,
   output logic             flag,
   output logic [CNT_W-1:0] count,
   output logic             armed
);

   localparam int FW = $clog2(WIDTH + 1);
   localparam logic [FW-1:0]    FILL_MAX  = FW'(WIDTH);
   localparam logic [FW-1:0]    FILL_MIN1 = FW'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [WIDTH-1:0] hist_q, hist_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             flag_q, flag_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] shifted;
   logic             match;

   // The FILLING/ARMED state is carried entirely by fill_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q  <= '0;
         pat_q   <= DEFAULT_PAT;
         fill_q  <= '0;
         flag_q  <= 1'b0;
         count_q <= '0;
      end else begin
         hist_q  <= hist_d;
         pat_q   <= pat_d;
         fill_q  <= fill_d;
         flag_q  <= flag_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      hist_d  = hist_q;
      pat_d   = pat_q;
      fill_d  = fill_q;
      flag_d  = 1'b0;
      count_d = count_q;
      match   = 1'b0;
      shifted = {hist_q[WIDTH-2:0], seq};

      if (pat_load) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (seq_vld) begin
         // Requiring WIDTH-1 prior valid bits keeps zero-filled history from matching.
         match  = (fill_q >= FILL_MIN1) && (shifted == pat_q);
         hist_d = shifted;
         flag_d = match;
         if (match && !OVERLAP)
            fill_d = '0;
         else if (fill_q != FILL_MAX)
            fill_d = fill_q + FW'(1);
      end

      // A match on the clearing edge counts as the first match after the clear.
      if (match)
         count_d = cnt_clr ? CNT_W'(1)
                           : ((count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1));
      else if (cnt_clr)
         count_d = '0;
   end

   always_comb begin
      armed = (fill_q == FILL_MAX);
      flag  = flag_q;
      count = count_q;
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: overlapping, non-overlapping and 2-bit-counter instances on shared stimulus.
// Table-driven vectors feed a scoreboard queue; reset behaviour is checked by a hand-written sequence.
module tb_seq_detect_param;

   typedef struct {
      logic       fa;
      logic [7:0] ca;
      logic       aa;
      logic       fb;
      logic [7:0] cb;
      logic       ab;
      logic [1:0] cc;
   } exp_t;

   typedef struct {
      logic       s;
      logic       v;
      logic       ld;
      logic       clr;
      logic [4:0] pin;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       seq = 1'b0;
   logic       seq_vld = 1'b0;
   logic [4:0] pat_in = 5'd0;
   logic       pat_load = 1'b0;
   logic       cnt_clr = 1'b0;

   logic       flag_a, armed_a, flag_b, armed_b, flag_c, armed_c;
   logic [7:0] count_a, count_b;
   logic [1:0] count_c;

   int errors = 0;
   int checks = 0;

   vec_t tbl[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   seq_detect_param u_a (
      .clk(clk), .reset(reset), .seq(seq), .seq_vld(seq_vld), .pat_in(pat_in),
      .pat_load(pat_load), .cnt_clr(cnt_clr), .flag(flag_a), .count(count_a), .armed(armed_a));

   seq_detect_param #(.OVERLAP(1'b0)) u_b (
      .clk(clk), .reset(reset), .seq(seq), .seq_vld(seq_vld), .pat_in(pat_in),
      .pat_load(pat_load), .cnt_clr(cnt_clr), .flag(flag_b), .count(count_b), .armed(armed_b));

   seq_detect_param #(.CNT_W(2)) u_c (
      .clk(clk), .reset(reset), .seq(seq), .seq_vld(seq_vld), .pat_in(pat_in),
      .pat_load(pat_load), .cnt_clr(cnt_clr), .flag(flag_c), .count(count_c), .armed(armed_c));

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic v, input logic ld, input logic clr,
                      input logic [4:0] pin,
                      input logic fa, input logic [7:0] ca, input logic aa,
                      input logic fb, input logic [7:0] cb, input logic ab,
                      input logic [1:0] cc);
      vec_t r;
      r.s = s; r.v = v; r.ld = ld; r.clr = clr; r.pin = pin;
      r.e.fa = fa; r.e.ca = ca; r.e.aa = aa;
      r.e.fb = fb; r.e.cb = cb; r.e.ab = ab; r.e.cc = cc;
      tbl.push_back(r);
   endtask

   task automatic drive(input vec_t r, input int idx);
      exp_t e;
      @(negedge clk);
      seq      = r.s;
      seq_vld  = r.v;
      pat_load = r.ld;
      cnt_clr  = r.clr;
      pat_in   = r.pin;
      sb.push_back(r.e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("flag_ovl",   idx, {7'd0, flag_a},  {7'd0, e.fa});
      chk("count_ovl",  idx, count_a,         e.ca);
      chk("armed_ovl",  idx, {7'd0, armed_a}, {7'd0, e.aa});
      chk("flag_novl",  idx, {7'd0, flag_b},  {7'd0, e.fb});
      chk("count_novl", idx, count_b,         e.cb);
      chk("armed_novl", idx, {7'd0, armed_b}, {7'd0, e.ab});
      chk("count_sat2", idx, {6'd0, count_c}, {6'd0, e.cc});
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_flag_ovl"},   0, {7'd0, flag_a},  8'd0);
      chk({name, "_count_ovl"},  0, count_a,         8'd0);
      chk({name, "_armed_ovl"},  0, {7'd0, armed_a}, 8'd0);
      chk({name, "_flag_novl"},  0, {7'd0, flag_b},  8'd0);
      chk({name, "_count_novl"}, 0, count_b,         8'd0);
      chk({name, "_armed_novl"}, 0, {7'd0, armed_b}, 8'd0);
      chk({name, "_flag_sat2"},  0, {7'd0, flag_c},  8'd0);
      chk({name, "_count_sat2"}, 0, {6'd0, count_c}, 8'd0);
      chk({name, "_armed_sat2"}, 0, {7'd0, armed_c}, 8'd0);
   endtask

   initial begin
      // Default pattern 10010, stream 1,0,0,1,0,0,1,0 then 0,1
      //   s  v  ld clr pin        fa ca aa  fb cb ab  cc
      add(1, 1, 0, 0, 5'b00000,  0, 0, 0,  0, 0, 0,  0);
      add(0, 1, 0, 0, 5'b00000,  0, 0, 0,  0, 0, 0,  0);
      add(0, 1, 0, 0, 5'b00000,  0, 0, 0,  0, 0, 0,  0);
      add(1, 1, 0, 0, 5'b00000,  0, 0, 0,  0, 0, 0,  0);
      add(0, 1, 0, 0, 5'b00000,  1, 1, 1,  1, 1, 0,  1);
      add(0, 1, 0, 0, 5'b00000,  0, 1, 1,  0, 1, 0,  1);
      add(1, 1, 0, 0, 5'b00000,  0, 1, 1,  0, 1, 0,  1);
      add(0, 1, 0, 0, 5'b00000,  1, 2, 1,  0, 1, 0,  2);
      add(0, 1, 0, 0, 5'b00000,  0, 2, 1,  0, 1, 0,  2);
      add(1, 1, 0, 0, 5'b00000,  0, 2, 1,  0, 1, 1,  2);
      // Load 00000 with a valid 1 on the same edge (discarded), counters cleared
      add(1, 1, 1, 1, 5'b00000,  0, 0, 0,  0, 0, 0,  0);
      for (int k = 1; k <= 10; k++) begin
         logic [7:0] ca;
         logic [1:0] cc;
         ca = (k >= 5) ? 8'(k - 4) : 8'd0;
         cc = (k >= 7) ? 2'd3 : ca[1:0];
         add(0, 1, 0, 0, 5'b00000, (k >= 5), ca, (k >= 5),
             (k == 5 || k == 10), (k >= 10) ? 8'd2 : ((k >= 5) ? 8'd1 : 8'd0), 0, cc);
      end
      // Clear on a matching edge: the match wins
      add(0, 1, 0, 1, 5'b00000,  1, 1, 1,  0, 0, 0,  1);
      // Load 11011 mid-stream with a valid bit, then 1,1,0,1,1
      add(1, 1, 1, 0, 5'b11011,  0, 1, 0,  0, 0, 0,  1);
      add(1, 1, 0, 0, 5'b00000,  0, 1, 0,  0, 0, 0,  1);
      add(1, 1, 0, 0, 5'b00000,  0, 1, 0,  0, 0, 0,  1);
      add(0, 1, 0, 0, 5'b00000,  0, 1, 0,  0, 0, 0,  1);
      add(1, 1, 0, 0, 5'b00000,  0, 1, 0,  0, 0, 0,  1);
      add(1, 1, 0, 0, 5'b00000,  1, 2, 1,  1, 1, 0,  2);
      // Same stream with three invalid cycles between bits 2 and 3
      add(1, 1, 0, 0, 5'b00000,  0, 2, 1,  0, 1, 0,  2);
      add(1, 1, 0, 0, 5'b00000,  0, 2, 1,  0, 1, 0,  2);
      add(1, 0, 0, 0, 5'b00000,  0, 2, 1,  0, 1, 0,  2);
      add(1, 0, 0, 0, 5'b00000,  0, 2, 1,  0, 1, 0,  2);
      add(1, 0, 0, 0, 5'b00000,  0, 2, 1,  0, 1, 0,  2);
      add(0, 1, 0, 0, 5'b00000,  0, 2, 1,  0, 1, 0,  2);
      add(1, 1, 0, 0, 5'b00000,  0, 2, 1,  0, 1, 0,  2);
      add(1, 1, 0, 0, 5'b00000,  1, 3, 1,  1, 2, 0,  3);
      // Three bits of 11011 before the reset pulse
      add(1, 1, 0, 0, 5'b00000,  0, 3, 1,  0, 2, 0,  3);
      add(1, 1, 0, 0, 5'b00000,  0, 3, 1,  0, 2, 0,  3);
      add(0, 1, 0, 0, 5'b00000,  0, 3, 1,  0, 2, 0,  3);

      #1;
      chk_all_zero("reset_state");
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;

      foreach (tbl[i]) drive(tbl[i], i);

      // Asynchronous reset for 7 ns mid-pattern
      @(negedge clk);
      seq_vld = 1'b0;
      pat_load = 1'b0;
      cnt_clr = 1'b0;
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      #6;
      reset = 1'b0;

      // Remaining bits 1,1 produce nothing; then 1,0,0,1,0 completes the default pattern once
      tbl.delete();
      add(1, 1, 0, 0, 5'b00000,  0, 0, 0,  0, 0, 0,  0);
      add(1, 1, 0, 0, 5'b00000,  0, 0, 0,  0, 0, 0,  0);
      add(1, 1, 0, 0, 5'b00000,  0, 0, 0,  0, 0, 0,  0);
      add(0, 1, 0, 0, 5'b00000,  0, 0, 0,  0, 0, 0,  0);
      add(0, 1, 0, 0, 5'b00000,  0, 0, 1,  0, 0, 1,  0);
      add(1, 1, 0, 0, 5'b00000,  0, 0, 1,  0, 0, 1,  0);
      add(0, 1, 0, 0, 5'b00000,  1, 1, 1,  1, 1, 0,  1);
      add(0, 0, 0, 0, 5'b00000,  0, 1, 1,  0, 1, 0,  1);
      foreach (tbl[i]) drive(tbl[i], 100 + i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
